// File: rtl/mem_ctrl_if.sv
// Requester-side bundle of mem_ctrl: fetch and
// MEM-stage handshakes plus the busy flag.
interface mem_ctrl_if;
  logic        if_re_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic [31:0] if_data_o;
  logic        if_done_o;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [1:0]  mem_width_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;
  logic        busy_o;

  modport slave (
    input  if_re_i,
    input  if_addr_i,
    input  if_flush_i,
    output if_data_o,
    output if_done_o,
    input  mem_re_i,
    input  mem_we_i,
    input  mem_addr_i,
    input  mem_width_i,
    input  mem_wdata_i,
    output mem_rdata_o,
    output mem_done_o,
    output busy_o
  );

  modport master (
    output if_re_i,
    output if_addr_i,
    output if_flush_i,
    input  if_data_o,
    input  if_done_o,
    output mem_re_i,
    output mem_we_i,
    output mem_addr_i,
    output mem_width_i,
    output mem_wdata_i,
    input  mem_rdata_o,
    input  mem_done_o,
    input  busy_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller serving fetch and
// MEM-stage requests over one byte-wide RAM.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  mem_ctrl_if.slave         bus,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [1:0] {
    IDLE,
    IF_RD,
    MEM_RD,
    MEM_WR
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  len_q, len_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  dout_q, dout_d;
  logic        wr_q, wr_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;

  logic [2:0]        nxt;
  logic              last;
  logic [31:0]       asm_ins;
  logic [7:0]        wbyte;
  logic [2:0]        mem_len;
  logic [ADDR_W-1:0] if_a;
  logic [ADDR_W-1:0] mem_a;
  logic [ADDR_W-1:0] step_a;
  logic              unused_addr;

  assign if_a  = bus.if_addr_i[ADDR_W-1:0];
  assign mem_a = bus.mem_addr_i[ADDR_W-1:0];
  assign unused_addr = ^{
    bus.if_addr_i[31:ADDR_W],
    bus.mem_addr_i[31:ADDR_W]
  };

  assign mem_len =
    (bus.mem_width_i == 2'd0) ? 3'd1 :
    (bus.mem_width_i == 2'd1) ? 3'd2 :
                                3'd4;

  // cnt_q is the index of the byte handled
  // at the coming edge; nxt is one past it.
  assign nxt    = {1'b0, cnt_q} + 3'd1;
  assign last   = (nxt == len_q);
  assign step_a = addr_q + ADDR_W'(nxt);
  assign wbyte  = wdata_q[{nxt[1:0], 3'b000} +: 8];
  assign asm_ins = asm_q |
    ({24'd0, ram_din_i} << {cnt_q, 3'b000});

  // State register, frozen while rdy is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Arbitration and transfer sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_we_i) begin
          state_d = MEM_WR;
        end else if (bus.mem_re_i) begin
          state_d = MEM_RD;
        end else if (bus.if_re_i &&
                     !bus.if_flush_i) begin
          state_d = IF_RD;
        end
      end
      IF_RD: begin
        if (bus.if_flush_i || last) begin
          state_d = IDLE;
        end
      end
      MEM_RD, MEM_WR: begin
        if (last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; done flags pulse
  always_comb begin
    addr_d     = addr_q;
    ram_a_d    = ram_a_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    if_data_d  = if_data_q;
    rdata_d    = rdata_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    wr_d       = wr_q;
    if_done_d  = 1'b0;
    mem_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = 2'd0;
        unique case (state_d)
          MEM_WR: begin
            addr_d  = mem_a;
            ram_a_d = mem_a;
            len_d   = mem_len;
            wdata_d = bus.mem_wdata_i;
            dout_d  = bus.mem_wdata_i[7:0];
            wr_d    = 1'b1;
          end
          MEM_RD: begin
            addr_d  = mem_a;
            ram_a_d = mem_a;
            len_d   = mem_len;
            asm_d   = '0;
          end
          IF_RD: begin
            addr_d  = if_a;
            ram_a_d = if_a;
            len_d   = 3'd4;
            asm_d   = '0;
          end
          default: begin
          end
        endcase
      end
      IF_RD: begin
        if (!bus.if_flush_i) begin
          asm_d = asm_ins;
          if (last) begin
            if_data_d = asm_ins;
            if_done_d = 1'b1;
          end else begin
            cnt_d   = nxt[1:0];
            ram_a_d = step_a;
          end
        end
      end
      MEM_RD: begin
        asm_d = asm_ins;
        if (last) begin
          rdata_d    = asm_ins;
          mem_done_d = 1'b1;
        end else begin
          cnt_d   = nxt[1:0];
          ram_a_d = step_a;
        end
      end
      MEM_WR: begin
        if (last) begin
          wr_d       = 1'b0;
          mem_done_d = 1'b1;
        end else begin
          cnt_d   = nxt[1:0];
          ram_a_d = step_a;
          dout_d  = wbyte;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers, frozen while rdy is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      ram_a_q    <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      if_data_q  <= '0;
      rdata_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
      wr_q       <= 1'b0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
    end else if (rdy) begin
      addr_q     <= addr_d;
      ram_a_q    <= ram_a_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      if_data_q  <= if_data_d;
      rdata_q    <= rdata_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      wr_q       <= wr_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
    end
  end

  assign ram_a_o         = ram_a_q;
  assign ram_dout_o      = dout_q;
  assign ram_wr_o        = wr_q;
  assign bus.if_data_o   = if_data_q;
  assign bus.if_done_o   = if_done_q;
  assign bus.mem_rdata_o = rdata_q;
  assign bus.mem_done_o  = mem_done_q;
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial RAM controller sitting directly upstream of the fetch stage and the MEM stage.
- Serves 32-bit instruction fetches (the fetch stage's ram_re / ram_busy / ram_done handshake) and load/store requests of width 1, 2 or 4 bytes.
- Drives one byte-wide synchronous RAM whose read data arrives one cycle after the address.
- Arbitrates the two requesters, with the MEM stage taking priority.

Parameters:
- ADDR_W, 17, RAM address width; request addresses use bits [ADDR_W-1:0] only.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rdy  in  1  global enable; low freezes all state
- if_re_i  in  1  fetch request (level)
- if_addr_i  in  32  fetch address
- if_flush_i  in  1  cancel an in-flight fetch
- if_data_o  out  32  fetched word, little-endian
- if_done_o  out  1  one-cycle pulse, if_data_o valid
- mem_re_i  in  1  load request (level)
- mem_we_i  in  1  store request (level)
- mem_addr_i  in  32  load/store address
- mem_width_i  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- mem_wdata_i  in  32  store data; low N bytes are used
- mem_rdata_o  out  32  load data, zero-extended
- mem_done_o  out  1  one-cycle pulse, load/store complete
- busy_o  out  1  high when state is not IDLE
- ram_a_o  out  ADDR_W  RAM address, registered
- ram_dout_o  out  8  RAM write byte, registered
- ram_wr_o  out  1  RAM write enable, registered
- ram_din_i  in  8  RAM read byte, valid the cycle after its address

Behaviour:
- Reset (rst_n low, any time, including mid-transfer):
  - state goes to IDLE.
  - All outputs go to 0; the byte counter and the data assembly registers clear.
  - A transfer interrupted by reset is abandoned and produces no done pulse.
- rdy low: every register holds its value. ram_wr_o stays at its held value; rewriting the same byte is idempotent.
- States: IDLE, IF_RD, MEM_RD, MEM_WR.
- Arbitration in IDLE, evaluated at each edge:
  - mem_we_i goes to MEM_WR; else mem_re_i goes to MEM_RD; else if_re_i goes to IF_RD.
  - Requests are sampled only in IDLE; inputs are ignored while busy.
  - N = 4 for a fetch; N = 1, 2 or 4 from mem_width_i for loads and stores.
  - The address and store data are latched at acceptance.
- Read sequence, with acceptance edge E0:
  - E0: ram_a_o <= A.
  - Edge Ek, k = 1..N: byte k-1 <= ram_din_i; if k < N, ram_a_o <= A+k.
  - EN: state <= IDLE; the done pulse for the requester is registered high.
  - Done is high exactly in the cycle after EN, with data stable in that cycle. Data outputs hold until the next completion of the same port.
  - Latency: a 4-byte fetch has done high 5 cycles after the cycle in which the request was sampled.
- Write sequence:
  - E0: ram_a_o <= A, ram_dout_o <= byte0, ram_wr_o <= 1.
  - Ek, k < N: address A+k, byte k.
  - EN: ram_wr_o <= 0, mem_done_o pulse, IDLE.
  - ram_wr_o is high for exactly N cycles.
- Address arithmetic is modulo 2^ADDR_W; A+k wraps. Unaligned addresses are legal.
- Back-to-back requests: a new request can be accepted at EN+1, i.e. one idle cycle between transfers. A held if_re_i re-fetches in that case; the fetch stage drops the request when it has its word.
- if_flush_i:
  - In IF_RD: at the next edge, state <= IDLE, the fetch is discarded, and no if_done_o is produced. A flush on the edge that would complete the fetch also suppresses it.
  - In IDLE with if_re_i asserted: the flush blocks acceptance on that edge.
  - if_flush_i has no effect on MEM_RD or MEM_WR.
- Simultaneous if_re_i and mem_re_i: the MEM transfer runs first and the fetch waits. busy_o is high throughout.
- busy_o = (state != IDLE), combinational from the state register.

Test Plan:
- Fetch at 0x00010 with RAM bytes 13 00 00 93 → if_data_o = 0x93000013 with if_done_o high 5 cycles after the request cycle; ram_a_o steps 0x10 to 0x13; ram_wr_o stays 0.
- Store word 0xDEADBEEF at 0x100 → 4 cycles of ram_wr_o writing EF, BE, AD, DE at 0x100–0x103, then one mem_done_o pulse. A following byte load from 0x102 returns mem_rdata_o = 0x000000AD.
- if_re_i and mem_re_i (half, 0x1FFFF, ADDR_W = 17) raised in the same cycle → MEM transfer first; addresses 0x1FFFF then 0x00000 (wrap); mem_done_o, then the fetch starts one cycle later.
- if_flush_i pulsed in the third cycle of a fetch → back in IDLE next edge, no if_done_o, if_data_o unchanged.
- rst_n dropped mid-store after 2 bytes → outputs 0 immediately (asynchronous), no further RAM writes, no mem_done_o.
- rdy held low for 3 cycles mid-fetch → ram_a_o and the counter frozen; completion is delayed by exactly 3 cycles with correct data.
